// File: rtl/tl45_pkg.sv
// Shared definitions for the TL45 multiply/divide sequencer.
package tl45_pkg;

  localparam logic [4:0] OP_MUL  = 5'h03;
  localparam logic [4:0] OP_DIV  = 5'h17;
  localparam logic [4:0] OP_UDIV = 5'h18;

  typedef logic [3:0] regnum_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL_WAIT,
    ST_DIV_START,
    ST_DIV_WAIT,
    ST_DRAIN,
    ST_DONE
  } tl45_mds_state_t;

endpackage

// File: rtl/tl45_md_timer.sv
// Loadable down-counter with a zero flag; times both the multiplier
// latency and the divider timeout.
module tl45_md_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // Load takes priority; counting stops at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/tl45_muldiv_seq.sv
// Sequencer for the shared pipelined multiplier and iterative divider of
// the TL45 execute stage: launches the unit, stalls, delivers one beat.
module tl45_muldiv_seq
  import tl45_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 4,
  parameter int unsigned DIV_TIMEOUT = 64
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_valid,
  input  logic [4:0]  i_opcode,
  input  logic [3:0]  i_dr,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_flush,
  output logic        o_stall,
  output logic        o_valid,
  output logic [3:0]  o_dr,
  output logic [31:0] o_value,
  output logic        o_err,
  output logic [31:0] o_mul_a,
  output logic [31:0] o_mul_b,
  input  logic [63:0] i_mul_result,
  output logic        o_div_wr,
  output logic        o_div_signed,
  output logic [31:0] o_div_n,
  output logic [31:0] o_div_d,
  input  logic        i_div_busy,
  input  logic        i_div_valid,
  input  logic        i_div_err,
  input  logic [31:0] i_div_result
);

  localparam int unsigned TMAX = (DIV_TIMEOUT > MUL_LATENCY) ? DIV_TIMEOUT : MUL_LATENCY;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam bit          TIMEOUT_EN = (DIV_TIMEOUT != 0);
  // Timer counts down to zero, so loads are one less than the cycle count.
  localparam logic [TW-1:0] MUL_LOAD = TW'(MUL_LATENCY - 1);
  localparam logic [TW-1:0] DIV_LOAD = TIMEOUT_EN ? TW'(DIV_TIMEOUT - 1) : '0;

  tl45_mds_state_t state, state_n;
  regnum_t         dr_q;
  logic [31:0]     value_q;
  logic            err_q;

  logic            is_md, is_mul;
  logic            accept_mul, accept_div, cap_mul, cap_div, abort, beat;
  logic            div_end;
  logic            tmr_load, tmr_en, tmr_expired;
  logic [TW-1:0]   tmr_load_value;

  // Only the low product word is architecturally visible.
  logic unused_mul_hi;
  assign unused_mul_hi = ^i_mul_result[63:32];

  assign is_mul  = (i_opcode == OP_MUL);
  assign is_md   = i_valid & (is_mul | (i_opcode == OP_DIV) | (i_opcode == OP_UDIV));
  assign div_end = i_div_valid | (TIMEOUT_EN & tmr_expired);

  tl45_md_timer #(.WIDTH(TW)) u_timer (
    .clk        (i_clk),
    .rst_n      (i_reset_n),
    .load       (tmr_load),
    .load_value (tmr_load_value),
    .en         (tmr_en),
    .expired    (tmr_expired)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= ST_IDLE;
    else            state <= state_n;
  end

  // Next-state, stall, strobes and capture enables.
  always_comb begin
    state_n        = state;
    o_stall        = 1'b0;
    o_div_wr       = 1'b0;
    beat           = 1'b0;
    accept_mul     = 1'b0;
    accept_div     = 1'b0;
    cap_mul        = 1'b0;
    cap_div        = 1'b0;
    abort          = 1'b0;
    tmr_load       = 1'b0;
    tmr_load_value = MUL_LOAD;
    tmr_en         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (is_md && !i_flush) begin
          o_stall  = 1'b1;
          tmr_load = 1'b1;
          if (is_mul) begin
            accept_mul = 1'b1;
            state_n    = ST_MUL_WAIT;
          end else begin
            accept_div = 1'b1;
            state_n    = ST_DIV_START;
          end
        end
      end
      ST_MUL_WAIT: begin
        o_stall = 1'b1;
        if (i_flush) begin
          state_n = ST_IDLE;
        end else if (tmr_expired) begin
          cap_mul = 1'b1;
          state_n = ST_DONE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_DIV_START: begin
        o_stall = 1'b1;
        if (i_flush) begin
          state_n = ST_IDLE;
        end else if (!i_div_busy) begin
          o_div_wr       = 1'b1;
          tmr_load       = 1'b1;
          tmr_load_value = DIV_LOAD;
          state_n        = ST_DIV_WAIT;
        end
      end
      ST_DIV_WAIT: begin
        o_stall = 1'b1;
        tmr_en  = 1'b1;
        // A divider finishing in the flush cycle needs no drain.
        if (div_end) begin
          state_n = i_flush ? ST_IDLE : ST_DONE;
          cap_div = i_div_valid & ~i_flush;
          abort   = ~i_div_valid & ~i_flush;
        end else if (i_flush) begin
          state_n = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        o_stall = 1'b1;
        tmr_en  = 1'b1;
        if (div_end) state_n = ST_IDLE;
      end
      ST_DONE: begin
        beat    = ~i_flush;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Operand launch registers and result capture.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_mul_a      <= '0;
      o_mul_b      <= '0;
      o_div_n      <= '0;
      o_div_d      <= '0;
      o_div_signed <= 1'b0;
      dr_q         <= '0;
      value_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      if (accept_mul) begin
        o_mul_a <= i_a;
        o_mul_b <= i_b;
      end
      if (accept_div) begin
        o_div_n      <= i_a;
        o_div_d      <= i_b;
        o_div_signed <= (i_opcode == OP_DIV);
      end
      if (accept_mul || accept_div) dr_q <= i_dr;
      if (cap_mul) begin
        value_q <= i_mul_result[31:0];
        err_q   <= 1'b0;
      end else if (cap_div) begin
        value_q <= i_div_result;
        err_q   <= i_div_err;
      end else if (abort) begin
        value_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  assign o_valid = beat;
  assign o_dr    = beat ? dr_q : '0;
  assign o_value = beat ? value_q : '0;
  assign o_err   = beat & err_q;

endmodule

// File: tb/tb_tl45_muldiv_seq.sv
// Directed bench for tl45_muldiv_seq with transaction-level expectations.
module tb_tl45_muldiv_seq;
  import tl45_pkg::*;

  localparam int unsigned MUL_L = 4;
  localparam int unsigned DLAT  = 33;
  localparam int unsigned T_TO  = 8;

  logic        i_clk, i_reset_n, i_valid, i_flush;
  logic [4:0]  i_opcode;
  logic [3:0]  i_dr;
  logic [31:0] i_a, i_b;
  logic        o_stall, o_valid, o_err;
  logic [3:0]  o_dr;
  logic [31:0] o_value, o_mul_a, o_mul_b, o_div_n, o_div_d;
  logic [63:0] i_mul_result;
  logic        o_div_wr, o_div_signed;
  logic        i_div_busy, i_div_valid, i_div_err;
  logic [31:0] i_div_result;

  logic        t_valid;
  logic [4:0]  t_opcode;
  logic [3:0]  t_dr, t_odr;
  logic [31:0] t_a, t_b, t_ovalue, t_mul_a, t_mul_b, t_div_n, t_div_d;
  logic        t_stall, t_ovalid, t_oerr, t_div_wr, t_div_signed;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  tl45_muldiv_seq #(.MUL_LATENCY(MUL_L), .DIV_TIMEOUT(64)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .i_opcode(i_opcode),
    .i_dr(i_dr), .i_a(i_a), .i_b(i_b), .i_flush(i_flush), .o_stall(o_stall),
    .o_valid(o_valid), .o_dr(o_dr), .o_value(o_value), .o_err(o_err),
    .o_mul_a(o_mul_a), .o_mul_b(o_mul_b), .i_mul_result(i_mul_result),
    .o_div_wr(o_div_wr), .o_div_signed(o_div_signed), .o_div_n(o_div_n),
    .o_div_d(o_div_d), .i_div_busy(i_div_busy), .i_div_valid(i_div_valid),
    .i_div_err(i_div_err), .i_div_result(i_div_result)
  );

  // Second instance: short timeout, divider that never answers.
  tl45_muldiv_seq #(.MUL_LATENCY(MUL_L), .DIV_TIMEOUT(T_TO)) dut_to (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(t_valid), .i_opcode(t_opcode),
    .i_dr(t_dr), .i_a(t_a), .i_b(t_b), .i_flush(1'b0), .o_stall(t_stall),
    .o_valid(t_ovalid), .o_dr(t_odr), .o_value(t_ovalue), .o_err(t_oerr),
    .o_mul_a(t_mul_a), .o_mul_b(t_mul_b), .i_mul_result(64'd0),
    .o_div_wr(t_div_wr), .o_div_signed(t_div_signed), .o_div_n(t_div_n),
    .o_div_d(t_div_d), .i_div_busy(1'b0), .i_div_valid(1'b0),
    .i_div_err(1'b0), .i_div_result(32'd0)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Pipelined multiplier: product visible MUL_L cycles after the launch edge.
  logic [63:0] mul_pipe [0:MUL_L-2];
  always @(posedge i_clk) begin
    mul_pipe[0] <= {32'd0, o_mul_a} * {32'd0, o_mul_b};
    for (int k = 1; k < MUL_L - 1; k++) mul_pipe[k] <= mul_pipe[k-1];
  end
  assign i_mul_result = mul_pipe[MUL_L-2];

  // Iterative divider: valid pulse DLAT cycles after the start strobe.
  int          dcnt;
  logic [31:0] pend_n, pend_d;
  logic        pend_s;
  always @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      i_div_busy <= 1'b0; i_div_valid <= 1'b0; i_div_err <= 1'b0;
      i_div_result <= '0; dcnt <= 0;
    end else begin
      i_div_valid <= 1'b0; i_div_err <= 1'b0; i_div_result <= '0;
      if (o_div_wr) begin
        i_div_busy <= 1'b1; dcnt <= DLAT - 1;
        pend_n <= o_div_n; pend_d <= o_div_d; pend_s <= o_div_signed;
      end else if (i_div_busy) begin
        if (dcnt == 1) begin
          i_div_busy  <= 1'b0;
          i_div_valid <= 1'b1;
          if (pend_d == 0) i_div_err <= 1'b1;
          else if (pend_s) i_div_result <= $signed(pend_n) / $signed(pend_d);
          else i_div_result <= pend_n / pend_d;
        end else begin
          dcnt <= dcnt - 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          cyc;
    logic [3:0]  dr;
    logic [31:0] value;
    logic        err;
  } beat_t;
  beat_t exp_q[$];

  // Architectural result of an instruction.
  task automatic model_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] v, output logic e);
    logic [63:0] p;
    e = 1'b0; v = '0;
    if (op == OP_MUL) begin
      p = {32'd0, a} * {32'd0, b};
      v = p[31:0];
    end else if (b == 0) e = 1'b1;
    else if (op == OP_DIV) v = $signed(a) / $signed(b);
    else v = a / b;
  endtask

  task automatic push_exp(input int at, input logic [4:0] op, input logic [3:0] dr,
                          input logic [31:0] a, input logic [31:0] b);
    beat_t bt;
    bt.cyc = at; bt.dr = dr;
    model_op(op, a, b, bt.value, bt.err);
    exp_q.push_back(bt);
  endtask

  int          wr_count = 0, beat_count = 0;
  logic        wr_signed;
  logic [31:0] last_value;
  logic [3:0]  last_dr;
  logic        last_err;

  // Every cycle: a beat exactly when the model expects one, silence otherwise.
  always @(negedge i_clk) begin
    if (i_reset_n) begin
      if (o_div_wr) begin wr_count++; wr_signed = o_div_signed; end
      if (o_valid) begin
        beat_count++; last_value = o_value; last_dr = o_dr; last_err = o_err;
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++; failures++;
        $display("FAIL beat_missing: got none expected beat at cycle %0d", exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        check("beat_valid", o_valid, 1);
        check("beat_dr", o_dr, exp_q[0].dr);
        check("beat_value", o_value, exp_q[0].value);
        check("beat_err", o_err, exp_q[0].err);
        void'(exp_q.pop_front());
      end else begin
        check("no_beat", {o_valid, o_err, o_dr, o_value}, 0);
      end
    end
  end

  task automatic issue(input logic [4:0] op, input logic [3:0] dr, input logic [31:0] a,
                       input logic [31:0] b, output int c);
    @(posedge i_clk); #1;
    i_valid = 1'b1; i_opcode = op; i_dr = dr; i_a = a; i_b = b;
    c = cyc;
  endtask

  task automatic drop_inputs();
    i_valid = 1'b0; i_opcode = '0; i_dr = '0; i_a = '0; i_b = '0; i_flush = 1'b0;
  endtask

  // Hold the instruction while stalled, through the completing cycle.
  task automatic finish_op(output int stalls);
    bit done = 0;
    stalls = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge i_clk);
      if (!o_stall) begin done = 1; break; end
      stalls++;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL stall_timeout: got stall still high expected release within 200 cycles");
    end
    @(posedge i_clk); #1;
    drop_inputs();
  endtask

  initial begin
    int c, st, w0, b0, seen;
    i_reset_n = 1'b0; drop_inputs();
    t_valid = 1'b0; t_opcode = '0; t_dr = '0; t_a = '0; t_b = '0;
    repeat (3) @(negedge i_clk);
    check("rst_stall", o_stall, 0);
    check("rst_valid", o_valid, 0);
    check("rst_value", {o_dr, o_value, o_err}, 0);
    check("rst_mul_ops", {o_mul_a, o_mul_b}, 0);
    check("rst_div_ops", {o_div_n, o_div_d}, 0);
    check("rst_div_ctl", {o_div_wr, o_div_signed}, 0);
    #2 i_reset_n = 1'b1;

    // Non-md opcode and flushed md op are ignored.
    issue(5'h01, 4'd2, 32'd5, 32'd5, c);
    @(negedge i_clk); check("nonmd_stall", o_stall, 0);
    @(posedge i_clk); #1; i_opcode = OP_MUL; i_flush = 1'b1;
    @(negedge i_clk); check("flush_idle_stall", o_stall, 0);
    @(posedge i_clk); #1; drop_inputs();

    // MUL 7 x 6.
    w0 = wr_count; b0 = beat_count;
    issue(OP_MUL, 4'd3, 32'd7, 32'd6, c);
    push_exp(c + MUL_L + 1, OP_MUL, 4'd3, 32'd7, 32'd6);
    finish_op(st);
    check("mul_stall_cycles", st, MUL_L + 1);
    check("mul_literal", {last_dr, last_err, last_value}, {4'd3, 1'b0, 32'd42});
    check("mul_no_div_wr", wr_count - w0, 0);
    check("mul_one_beat", beat_count - b0, 1);

    // UDIV 100 / 7.
    w0 = wr_count;
    issue(OP_UDIV, 4'd5, 32'd100, 32'd7, c);
    push_exp(c + DLAT + 2, OP_UDIV, 4'd5, 32'd100, 32'd7);
    finish_op(st);
    check("udiv_stall_cycles", st, DLAT + 2);
    check("udiv_wr_pulses", wr_count - w0, 1);
    check("udiv_signed", wr_signed, 0);
    check("udiv_literal", last_value, 32'd14);

    // DIV -9 / 2.
    issue(OP_DIV, 4'd6, -32'sd9, 32'd2, c);
    push_exp(c + DLAT + 2, OP_DIV, 4'd6, -32'sd9, 32'd2);
    finish_op(st);
    check("div_signed", wr_signed, 1);
    check("div_literal", last_value, 32'hFFFF_FFFC);

    // DIV by zero.
    issue(OP_DIV, 4'd7, 32'd5, 32'd0, c);
    push_exp(c + DLAT + 2, OP_DIV, 4'd7, 32'd5, 32'd0);
    finish_op(st);
    check("div0_err", last_err, 1);

    // Flush mid-divide, then MUL 3 x 3 waits for the drain.
    w0 = wr_count; b0 = beat_count;
    issue(OP_UDIV, 4'd8, 32'd1000, 32'd3, c);
    repeat (5) @(posedge i_clk);
    #1; i_valid = 1'b0; i_flush = 1'b1;
    @(posedge i_clk); #1; i_flush = 1'b0;
    i_valid = 1'b1; i_opcode = OP_MUL; i_dr = 4'd9; i_a = 32'd3; i_b = 32'd3;
    push_exp(c + DLAT + 2 + MUL_L + 1, OP_MUL, 4'd9, 32'd3, 32'd3);
    finish_op(st);
    check("drain_stall_cycles", st, DLAT + MUL_L - 3);
    check("drain_wr_pulses", wr_count - w0, 1);
    check("drain_one_beat", beat_count - b0, 1);
    check("drain_mul_literal", {last_dr, last_value}, {4'd9, 32'd9});

    // Flush in the completing cycle suppresses the beat.
    b0 = beat_count;
    issue(OP_MUL, 4'd1, 32'd2, 32'd2, c);
    repeat (MUL_L + 1) @(posedge i_clk);
    #1; i_flush = 1'b1;
    @(posedge i_clk); #1; drop_inputs();
    @(negedge i_clk);
    check("done_flush_no_beat", beat_count - b0, 0);

    // Asynchronous reset mid-MUL_WAIT.
    issue(OP_MUL, 4'd2, 32'd11, 32'd13, c);
    repeat (2) @(posedge i_clk);
    #3; exp_q.delete(); drop_inputs(); i_reset_n = 1'b0;
    #1;
    check("arst_stall", o_stall, 0);
    check("arst_outs", {o_valid, o_err, o_dr, o_value}, 0);
    check("arst_mul_ops", {o_mul_a, o_mul_b}, 0);
    @(negedge i_clk); #2 i_reset_n = 1'b1;
    issue(OP_MUL, 4'd4, 32'd12, 32'd12, c);
    push_exp(c + MUL_L + 1, OP_MUL, 4'd4, 32'd12, 32'd12);
    finish_op(st);
    check("post_rst_stall_cycles", st, MUL_L + 1);
    check("post_rst_literal", last_value, 32'd144);

    // Divider timeout on the short-timeout instance.
    @(posedge i_clk); #1;
    t_valid = 1'b1; t_opcode = OP_DIV; t_dr = 4'hA; t_a = 32'd50; t_b = 32'd5;
    c = cyc; seen = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge i_clk);
      if (t_ovalid) begin
        seen = cyc;
        check("to_value", t_ovalue, 0);
        check("to_err", t_oerr, 1);
        check("to_dr", t_odr, 4'hA);
        check("to_stall_released", t_stall, 0);
        break;
      end
    end
    check("to_cycle", seen - c, T_TO + 2);
    @(posedge i_clk); #1; t_valid = 1'b0; t_opcode = '0;
    @(negedge i_clk);
    check("to_stall_idle", t_stall, 0);

    repeat (3) @(negedge i_clk);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000ns");
    $fatal(1, "watchdog");
  end

endmodule
